add_serial: RTL and testbench

ADD_SERIAL -- requirements
Module: add_serial

---
 rtl/add_pkg.sv | 32 +++
 rtl/add_serial_if.sv | 36 +++
 rtl/add_slice.sv | 33 +++
 rtl/full_adder.sv | 13 +
 rtl/add_serial.sv | 128 ++++++++++++
 tb/tb_add_serial.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the serial adder: FSM encodings, status-bus bit
// positions and small elaboration helpers.
package add_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit positions inside the packed status bus
    localparam int FLG_CARRY    = 0;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_ZERO     = 2;
    localparam int FLG_NEGATIVE = 3;
    localparam int FLG_W        = 4;

    typedef logic [FLG_W-1:0] status_t;

    // Status value after reset: the cleared sum reads as zero.
    function automatic status_t status_reset();
        status_t s;
        s = '0;
        s[FLG_ZERO] = 1'b1;
        return s;
    endfunction

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_serial_if.sv
// Operation request / result bus of the serial adder.
//
// Handshake: the master raises start for one or more cycles with sub, a and
// b valid in the same cycle. A request is taken on a rising edge only when
// the adder is not busy (IDLE or DONE); requests seen while busy is high are
// dropped, not queued. done is a one-cycle pulse marking the cycle in which
// sum and the flags first show the new result; these outputs then hold until
// the next done pulse. There is no backpressure on the result side.
interface add_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    // Requester side
    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry, overflow, zero, negative
    );

    // Adder side
    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry, overflow, zero, negative
    );

endinterface

// File: rtl/add_slice.sv
// SLICE-bit ripple-carry adder built from full_adder cells. Also exposes the
// carry into its top bit so the caller can form signed overflow on the last
// slice of an operation.
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    // Ripple chain, bit 0 first
    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[SLICE];
    assign cmsb = c[SLICE-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_serial.sv
// Serial adder/subtractor: adds WIDTH-bit operands SLICE bits per cycle.
// Subtraction is done as a + ~b + 1 by inverting b and seeding the carry when
// the request is taken. All outputs come straight from registers.
module add_serial
    import add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic       clk,
    input  logic       rst,
    add_serial_if.slave bus,
    output logic [1:0] state_dbg
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    // Reject illegal parameterisations at elaboration time
    if (WIDTH < 2) begin : g_bad_width
        $error("add_serial: WIDTH must be at least 2");
    end
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("add_serial: SLICE must divide WIDTH exactly");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             run_c;     // carry between slices
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;       // already inverted for subtraction
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_q;
    status_t          flags;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_cout;
    logic             sl_cmsb;
    logic [WIDTH-1:0] acc_next;
    status_t          flags_next;
    logic             last_slice;
    logic             accept;

    // Pick the slice of the latched operands addressed by idx
    always_comb begin
        sl_a = a_q[idx*SLICE +: SLICE];
        sl_b = b_q[idx*SLICE +: SLICE];
    end

    add_slice #(.SLICE(SLICE)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (run_c),
        .s    (sl_s),
        .cout (sl_cout),
        .cmsb (sl_cmsb)
    );

    // Accumulator with the current slice merged in, plus the flags it implies.
    // On the last slice these become the published result in one step, so the
    // sum and all flags change together on entry to DONE.
    always_comb begin
        acc_next = acc;
        acc_next[idx*SLICE +: SLICE] = sl_s;
        flags_next = '0;
        flags_next[FLG_CARRY]    = sl_cout;
        flags_next[FLG_OVERFLOW] = sl_cmsb ^ sl_cout;
        flags_next[FLG_ZERO]     = (acc_next == '0);
        flags_next[FLG_NEGATIVE] = acc_next[WIDTH-1];
    end

    assign last_slice = (idx == LAST_IDX);
    assign accept     = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

    // FSM, operand latch, slice stepping and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            run_c <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            sum_q <= '0;
            flags <= status_reset();
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b ^ {WIDTH{bus.sub}};
                        run_c <= bus.sub;
                        idx   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    run_c <= sl_cout;
                    idx   <= idx + 1'b1;
                    if (last_slice) begin
                        state <= ST_DONE;
                        sum_q <= acc_next;
                        flags <= flags_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = (state == ST_DONE);
    assign bus.sum      = sum_q;
    assign bus.carry    = flags[FLG_CARRY];
    assign bus.overflow = flags[FLG_OVERFLOW];
    assign bus.zero     = flags[FLG_ZERO];
    assign bus.negative = flags[FLG_NEGATIVE];
    assign state_dbg    = state;

endmodule

// File: tb/tb_add_serial.sv
// Bench for add_serial: a 16/4 instance for directed and random operations
// and a 16/16 instance for back-to-back single-slice operation.
module tb_add_serial;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_serial_if #(.WIDTH(W)) bus0 ();
  add_serial_if #(.WIDTH(W)) bus1 ();
  logic [1:0] st0;
  logic [1:0] st1;

  add_serial #(.WIDTH(W), .SLICE(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(st0)
  );

  add_serial #(.WIDTH(W), .SLICE(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  // {carry, overflow, zero, negative, sum}
  logic [W+3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0] full;
    logic [W-1:0] r;
    logic c;
    logic ov;
    int sr;
    if (s) begin
      r  = a - b;
      c  = (a >= b);
      sr = int'($signed(a)) - int'($signed(b));
    end else begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[W-1:0];
      c    = full[W];
      sr   = int'($signed(a)) + int'($signed(b));
    end
    ov = (sr > 32767) || (sr < -32768);
    return {c, ov, (r == '0), r[W-1], r};
  endfunction

  task automatic cmp_out(input string tag, input logic [W-1:0] sum, input logic c,
                         input logic ov, input logic z, input logic n, input logic [W+3:0] e);
    check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
    check({tag, "_carry"}, 32'(c), 32'(e[W+3]));
    check({tag, "_ovf"}, 32'(ov), 32'(e[W+2]));
    check({tag, "_zero"}, 32'(z), 32'(e[W+1]));
    check({tag, "_neg"}, 32'(n), 32'(e[W]));
  endtask

  // ---------------- drivers ----------------
  // Full operation on dut0: issue, check latency, result, pulse width, hold.
  task automatic op0(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
    logic [W+3:0] e;
    int lat;
    bit seen;
    exp_q.push_back(model(a, b, s));
    @(negedge clk);
    bus0.start = 1'b1; bus0.a = a; bus0.b = b; bus0.sub = s;
    @(negedge clk);
    bus0.start = 1'b0;
    bus0.a = W'($urandom); bus0.b = W'($urandom); bus0.sub = 1'($urandom_range(0, 1));
    check({tag, "_busy"}, 32'(bus0.busy), 32'd1);
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = bus0.done;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    e = exp_q.pop_front();
    if (seen) begin
      check({tag, "_latency"}, 32'(lat), 32'd5);
      check({tag, "_busy_at_done"}, 32'(bus0.busy), 32'd0);
      cmp_out(tag, bus0.sum, bus0.carry, bus0.overflow, bus0.zero, bus0.negative, e);
      @(negedge clk);
      check({tag, "_done_width"}, 32'(bus0.done), 32'd0);
      check({tag, "_hold"}, 32'(bus0.sum), 32'(e[W-1:0]));
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_state"}, 32'(st0), 32'd0);
    check({tag, "_busy"}, 32'(bus0.busy), 32'd0);
    check({tag, "_done"}, 32'(bus0.done), 32'd0);
    cmp_out(tag, bus0.sum, bus0.carry, bus0.overflow, bus0.zero, bus0.negative,
            {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W+3:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;
    logic [W-1:0] got_sum;
    int dones;

    bus0.start = 1'b0; bus0.sub = 1'b0; bus0.a = '0; bus0.b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset0("reset");
    rst = 1'b0;

    // Directed boundary cases
    op0(16'h7FFF, 16'h0001, 1'b0, "add_7fff_1");
    op0(16'hFFFF, 16'h0001, 1'b0, "add_ffff_1");
    op0(16'h8000, 16'h0001, 1'b1, "sub_8000_1");
    op0(16'h0005, 16'h0005, 1'b1, "sub_5_5");
    op0(16'h0000, 16'h0001, 1'b1, "sub_0_1");

    // Start while running is ignored
    dones = 0;
    got_sum = '0;
    e = model(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    bus0.start = 1'b1; bus0.a = 16'h1234; bus0.b = 16'h1111; bus0.sub = 1'b0;
    @(negedge clk);
    bus0.start = 1'b0;
    if (bus0.done) dones++;
    @(negedge clk);
    bus0.start = 1'b1; bus0.a = 16'hFFFF; bus0.b = 16'hFFFF;
    if (bus0.done) dones++;
    @(negedge clk);
    bus0.start = 1'b0;
    if (bus0.done) dones++;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus0.done) begin
        dones++;
        got_sum = bus0.sum;
      end
    end
    check("ignore_start_done_count", 32'(dones), 32'd1);
    check("ignore_start_sum", 32'(got_sum), 32'(e[W-1:0]));

    // Reset in the second RUN cycle aborts the operation
    @(negedge clk);
    bus0.start = 1'b1; bus0.a = 16'h1111; bus0.b = 16'h2222; bus0.sub = 1'b0;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset0("abort");
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus0.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    op0(16'h0003, 16'h0004, 1'b0, "after_abort");

    // Random operations
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i % 10 == 0) rb = ra;
      op0(ra, rb, rs, $sformatf("rand%0d", i));
    end

    // Single-slice instance, restarted in every DONE cycle
    ra = 16'h7FFF; rb = 16'h0001; rs = 1'b0;
    exp_q.push_back(model(ra, rb, rs));
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = ra; bus1.b = rb; bus1.sub = rs;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      check($sformatf("b2b%0d_busy", i), 32'(bus1.busy), 32'd1);
      check($sformatf("b2b%0d_run_nodone", i), 32'(bus1.done), 32'd0);
      @(negedge clk);
      check($sformatf("b2b%0d_done", i), 32'(bus1.done), 32'd1);
      e = exp_q.pop_front();
      cmp_out($sformatf("b2b%0d", i), bus1.sum, bus1.carry, bus1.overflow,
              bus1.zero, bus1.negative, e);
      if (i < 9) begin
        ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
        exp_q.push_back(model(ra, rb, rs));
        bus1.start = 1'b1; bus1.a = ra; bus1.b = rb; bus1.sub = rs;
      end
    end
    @(negedge clk);
    check("b2b_end_done", 32'(bus1.done), 32'd0);
    check("b2b_end_state", 32'(st1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
